// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding
// and default widths.
package mul_share_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int W_DEF       = 4;
    localparam int TIMEOUT_DEF = 63;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DELIVER = 3'd4
    } state_t;

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping
// modulo N_REQ, so the previous winner ends up with the lowest priority.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        gnt_oh = '0;
        idx    = '0;
        any    = |req;
        j      = 0;
        // Scan farthest offset first so the nearest set bit overwrites it.
        for (int k = N_REQ; k >= 1; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                gnt_oh    = '0;
                gnt_oh[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one sequential multiplier core among N_REQ clients,
// with start/ready handshake tracking and a sticky watchdog error flag.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [2*W-1:0]     result,
    output logic               mul_start,
    output logic [W-1:0]       mul_in_1,
    output logic [W-1:0]       mul_in_2,
    input  logic [2*W-1:0]     mul_out,
    input  logic               mul_ready,
    output logic               busy,
    output logic               err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]    wdog, wdog_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [W-1:0]     in_1_nxt, in_2_nxt;
    logic [2*W-1:0]   result_nxt;
    logic             err_nxt;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= IW'(N_REQ - 1);
            wdog     <= '0;
            gnt      <= '0;
            mul_in_1 <= '0;
            mul_in_2 <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            wdog     <= wdog_nxt;
            gnt      <= gnt_nxt;
            mul_in_1 <= in_1_nxt;
            mul_in_2 <= in_2_nxt;
            result   <= result_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        wdog_nxt   = wdog;
        gnt_nxt    = gnt;
        in_1_nxt   = mul_in_1;
        in_2_nxt   = mul_in_2;
        result_nxt = result;
        err_nxt    = err;
        mul_start  = 1'b0;
        done       = '0;

        case (state)
            IDLE: begin
                gnt_nxt = '0;
                // Only capture when the core is idle; operands are frozen here.
                if (pick_any && mul_ready) begin
                    state_nxt  = ISSUE;
                    gnt_nxt    = pick_oh;
                    rr_ptr_nxt = pick_idx;
                    in_1_nxt   = op_a[int'(pick_idx)*W +: W];
                    in_2_nxt   = op_b[int'(pick_idx)*W +: W];
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                wdog_nxt  = '0;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!mul_ready) begin
                    wdog_nxt  = '0;
                    state_nxt = WAIT_HI;
                end else if (wdog == CW'(TIMEOUT)) begin
                    err_nxt    = 1'b1;
                    result_nxt = '0;
                    state_nxt  = DELIVER;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            WAIT_HI: begin
                if (mul_ready) begin
                    result_nxt = mul_out;
                    state_nxt  = DELIVER;
                end else if (wdog == CW'(TIMEOUT)) begin
                    err_nxt    = 1'b1;
                    result_nxt = '0;
                    state_nxt  = DELIVER;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            DELIVER: begin
                done      = gnt;
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural 4x4 sequential
// multiplier core that can be switched into a never-completing mode.
module tb_mul_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a, op_b;
    logic [N-1:0]   gnt, done;
    logic [2*W-1:0] result;
    logic           mul_start;
    logic [W-1:0]   mul_in_1, mul_in_2;
    logic [2*W-1:0] mul_out;
    logic           mul_ready;
    logic           busy, err;

    int checks = 0;
    int errors = 0;

    logic           stuck;
    logic [W-1:0]   core_a, core_b;
    logic [2:0]     core_cnt;
    int             n_start;
    int             n_done;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(63)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .mul_start (mul_start),
        .mul_in_1  (mul_in_1),
        .mul_in_2  (mul_in_2),
        .mul_out   (mul_out),
        .mul_ready (mul_ready),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural core: ready drops after start, product appears 4 cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_ready <= 1'b1;
            mul_out   <= '0;
            core_a    <= '0;
            core_b    <= '0;
            core_cnt  <= '0;
        end else if (!stuck) begin
            if (mul_start && mul_ready) begin
                mul_ready <= 1'b0;
                core_a    <= mul_in_1;
                core_b    <= mul_in_2;
                core_cnt  <= 3'd3;
            end else if (!mul_ready) begin
                if (core_cnt == 0) begin
                    mul_ready <= 1'b1;
                    mul_out   <= core_a * core_b;
                end else begin
                    core_cnt <= core_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_start <= 0;
            n_done  <= 0;
        end else begin
            if (mul_start) n_start <= n_start + 1;
            if (done != '0) n_done <= n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},    32'(gnt), 0);
        chk({tag, "_done"},   32'(done), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_start"},  32'(mul_start), 0);
        chk({tag, "_in1"},    32'(mul_in_1), 0);
        chk({tag, "_in2"},    32'(mul_in_2), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_err"},    32'(err), 0);
    endtask

    task automatic wait_gnt(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt != '0) return;
        end
        chk("gnt_wait_expired", 0, 1);
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output logic [2*W-1:0] r);
        d = '0;
        r = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done != '0) begin
                d = done;
                r = result;
                chk("done_onehot", 32'($onehot(done)), 1);
                return;
            end
        end
        chk("done_wait_expired", 0, 1);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0]   d;
        logic [2*W-1:0] r;
        int             s0, d0, w;

        rst   = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        stuck = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;

        // Single request: 6*9
        set_ops(0, 4'd6, 4'd9);
        s0 = n_start;
        d0 = n_done;
        req = 4'b0001;
        wait_gnt(20);
        chk("single_gnt", 32'(gnt), 32'b0001);
        chk("single_start_high", 32'(mul_start), 1);
        wait_done(40, d, r);
        req = '0;
        chk("single_done", 32'(d), 32'b0001);
        chk("single_result", 32'(r), 54);
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 0);
        chk("single_start_count", 32'(n_start - s0), 1);
        chk("single_done_count", 32'(n_done - d0), 1);

        // Contention from fresh rr_ptr: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 4'(i + 1), 4'(i + 2));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = k % N;
            wait_done(40, d, r);
            chk("contend_done", 32'(d), 32'(1 << w));
            chk("contend_result", 32'(r), 32'((w + 1) * (w + 2)));
        end
        req = '0;

        // Operand change after grant
        set_ops(2, 4'd11, 4'd5);
        req = 4'b0100;
        wait_gnt(20);
        chk("opchg_gnt", 32'(gnt), 32'b0100);
        set_ops(2, 4'd3, 4'd5);
        wait_done(40, d, r);
        req = '0;
        chk("opchg_done", 32'(d), 32'b0100);
        chk("opchg_result", 32'(r), 55);

        // Exhaustive sweep on requester 1
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_ops(1, 4'(a), 4'(b));
                req = 4'b0010;
                wait_done(40, d, r);
                req = '0;
                chk("sweep_result", 32'(r), 32'(a * b));
            end
        end
        chk("sweep_done_last", 32'(d), 32'b0010);
        chk("sweep_no_err", 32'(err), 0);

        // Timeout: core never drops ready
        stuck = 1'b1;
        set_ops(0, 4'd7, 4'd7);
        req = 4'b0001;
        wait_gnt(20);
        chk("tmo_err_before", 32'(err), 0);
        repeat (30) @(negedge clk);
        chk("tmo_err_midway", 32'(err), 0);
        wait_done(100, d, r);
        req = '0;
        chk("tmo_done", 32'(d), 32'b0001);
        chk("tmo_result", 32'(r), 0);
        chk("tmo_err_set", 32'(err), 1);
        stuck = 1'b0;
        @(negedge clk);
        req = 4'b0001;
        wait_done(40, d, r);
        req = '0;
        chk("post_tmo_result", 32'(r), 49);
        chk("post_tmo_err_sticky", 32'(err), 1);

        // Reset during WAIT_HI
        set_ops(2, 4'd3, 4'd3);
        req = 4'b0100;
        wait_gnt(20);
        for (int c = 0; c < 20 && mul_ready; c++) @(negedge clk);
        chk("midrst_core_busy", 32'(mul_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("midrst");
        @(negedge clk);
        set_ops(2, 4'd2, 4'd5);
        set_ops(3, 4'd9, 4'd9);
        req = 4'b1100;
        rst = 1'b1;
        wait_gnt(20);
        chk("midrst_first_gnt", 32'(gnt), 32'b0100);
        wait_done(40, d, r);
        req = '0;
        chk("midrst_done", 32'(d), 32'b0100);
        chk("midrst_result", 32'(r), 10);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 4x4 sequential multiplier core (start/ready handshake, `in_1`/`in_2`/`out`) between N_REQ requesters.
- Round-robin arbitration.
- Captures the granted requester's operands and issues a one-cycle start to the core.
- Tracks the core's ready handshake, then returns the product with a done pulse to the winner.
- Watchdog flags a core that never completes.
- Sits between client blocks and the multiplier's start/ready interface; replaces direct `start` drive at the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand width; product is 2*W
- TIMEOUT, 63, max cycles waited in each WAIT state before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level
- op_a  in  N_REQ*W  packed operand A, requester i at bits [i*W +: W]
- op_b  in  N_REQ*W  packed operand B, same packing
- gnt  out  N_REQ  one-hot, high from capture cycle through done cycle
- done  out  N_REQ  one-hot, one-cycle pulse when result is valid
- result  out  2*W  product of last completed job, held until next DELIVER
- mul_start  out  1  one-cycle start pulse to core
- mul_in_1  out  W  registered operand A to core
- mul_in_2  out  W  registered operand B to core
- mul_out  in  2*W  core product
- mul_ready  in  1  core ready; high when idle or result valid
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async), all outputs at reset:
  - gnt=0, done=0, result=0, mul_start=0, mul_in_1/2=0, busy=0, err=0
  - rr_ptr=N_REQ-1, state=IDLE, wdog=0
  - Reset mid-job abandons the job silently; the core is reset by its own rst.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DELIVER.
- IDLE:
  - If any req bit is set and mul_ready=1: pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Latch that requester's op_a/op_b into mul_in_1/mul_in_2, set gnt one-hot, set rr_ptr to the winner, go to ISSUE.
  - If mul_ready=0, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; go to WAIT_LO; wdog cleared.
- WAIT_LO:
  - Wait for mul_ready=0 (core accepted the job), then go to WAIT_HI.
  - wdog increments each cycle; on wdog==TIMEOUT set err and go to DELIVER with result=0.
- WAIT_HI:
  - Wait for mul_ready=1, then register result<=mul_out and go to DELIVER.
  - Same timeout rule, with wdog cleared on entry.
- DELIVER: done[winner]=1 for one cycle, gnt remains for this cycle; go to IDLE, where gnt clears.
- Latency: capture to done = 4 + core busy cycles. Minimum back-to-back spacing is 1 IDLE cycle between jobs.
- Operand stability: operands are latched at capture, so a requester may change op_a/op_b after gnt rises.
- Request rules:
  - A requester holds req until its done pulse.
  - req dropped before grant is simply not serviced.
  - req dropped while granted does not abort the job; done still pulses.
  - req held high after done makes the requester eligible again, at lowest priority (rr_ptr just passed it).
- Simultaneous requests: strict round-robin, no starvation; each requester waits at most N_REQ-1 jobs.
- Single requester: always regranted.
- err is sticky until reset; arbitration continues after a timeout.
- Product width is 2*W with no truncation; result passes mul_out through unchanged.

Decomposition:
- Package mul_share_pkg:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT_LO=2, WAIT_HI=3, DELIVER=4
  - default widths
- Sub-module rr_pick (N_REQ):
  - combinational round-robin priority picker
  - inputs: req, rr_ptr
  - outputs: one-hot grant, binary index, any

Test Plan:
- Single request: req=0001, op_a[0]=6, op_b[0]=9, behavioural core → gnt=0001, one mul_start pulse, done=0001 once, result=54; busy low afterwards.
- Contention: req=1111 held continuously, requester i operands (i+1, i+2) → grant order 0,1,2,3,0; results 2, 6, 12, 20; each done strictly one-hot.
- Operand change after grant: op_a[2] changes from 11 to 3 one cycle after gnt, op_b[2]=5 → result=55.
- Exhaustive: requester 1 sweeps all 16x16 operand pairs → result equals a*b for every pair, no err.
- Timeout: core model holds mul_ready=1 forever after start → err=1 after 63 cycles in WAIT_LO, done pulses with result=0; the next job on a good core still completes correctly.
- Reset mid-job: rst low during WAIT_HI → all outputs 0 immediately (async). After release, req=0100 is granted first, since rr_ptr was reset to N_REQ-1.
